hexa_digits_display_mux: RTL

- Drives a 4-digit, common-anode, multiplexed 7-segment display from three 4-bit hex digits (`unidad`, `decena`, `centena`).
- Sits directly downstream of the byte-to-hex-digits splitter and feeds the board's `an`/`seg`/`dp` pins.
- Captures the digits on a load strobe, scans one digit per refresh slot with an anti-ghosting blank interval, decodes 0–F to segments, and optionally blanks leading zeros.

---
 rtl/hexa_digits_display_mux.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hexa_digits_display_mux.sv
// Multiplexed 4-digit common-anode 7-segment driver for three latched hex digits.
// Scans one slot per REFRESH_DIV cycles, blanks the start of each slot and can suppress leading zeros.
module hexa_digits_display_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLANK_LZ     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cargar,
  input  logic [3:0] unidad,
  input  logic [3:0] decena,
  input  logic [3:0] centena,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int            CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic          LZ_EN   = (BLANK_LZ != 0);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } slot_e;

  slot_e         slot_q, slot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    d0_q, d1_q, d2_q;
  logic [3:0]    d0_d, d1_d, d2_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q;

  logic [3:0]    digit_s;
  logic [3:0]    sel_an_s;
  logic          lz_blank_s;
  logic          in_blank_s;
  logic          lit_s;

  // Active-low gfedcba pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // A zero-length blank interval would otherwise be an always-false compare.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank_s = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
      assign in_blank_s = (cnt_q < BLANK_C);
    end
  endgenerate

  // Next-state for counter, slot, digit latches, and the output pattern for the current slot.
  always_comb begin
    cnt_d      = cnt_q + CW'(1);
    slot_d     = slot_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    digit_s    = d0_q;
    sel_an_s   = 4'b1110;
    lz_blank_s = 1'b0;

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      case (slot_q)
        S0:      slot_d = S1;
        S1:      slot_d = S2;
        S2:      slot_d = S3;
        S3:      slot_d = S0;
        default: slot_d = S0;
      endcase
    end else begin
      slot_d = slot_q;
    end

    if (cargar) begin
      d0_d = unidad;
      d1_d = decena;
      d2_d = centena;
    end else begin
      d0_d = d0_q;
    end

    case (slot_q)
      S0: begin
        digit_s  = d0_q;
        sel_an_s = 4'b1110;
      end
      S1: begin
        digit_s    = d1_q;
        sel_an_s   = 4'b1101;
        lz_blank_s = LZ_EN && (d2_q == 4'd0) && (d1_q == 4'd0);
      end
      S2: begin
        digit_s    = d2_q;
        sel_an_s   = 4'b1011;
        lz_blank_s = LZ_EN && (d2_q == 4'd0);
      end
      S3: begin
        sel_an_s = 4'b1111;
      end
      default: begin
        sel_an_s = 4'b1111;
      end
    endcase

    lit_s = !in_blank_s && !lz_blank_s && (slot_q != S3);
    if (lit_s) begin
      an_d  = sel_an_s;
      seg_d = hex_to_seg(digit_s);
    end else begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end
  end

  // State and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      slot_q <= S0;
      d0_q   <= 4'd0;
      d1_q   <= 4'd0;
      d2_q   <= 4'd0;
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      d0_q   <= d0_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= 1'b1;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
